// File: rtl/bp_mem_cmd_arbiter_if.sv
// Two-requester memory command channel: per-requester header/data inputs plus
// the single arbitrated header/data output toward the off-core link.
interface bp_mem_cmd_arbiter_if #(
   parameter int hdr_width_p  = 88,
   parameter int data_width_p = 64
);
   logic [2*hdr_width_p-1:0]  hdr_i;
   logic [1:0]                hdr_v_i;
   logic [1:0]                hdr_yumi_o;
   logic [2*data_width_p-1:0] data_i;
   logic [1:0]                data_v_i;
   logic [1:0]                data_yumi_o;
   logic [hdr_width_p-1:0]    hdr_o;
   logic                      hdr_v_o;
   logic                      hdr_ready_i;
   logic [data_width_p-1:0]   data_o;
   logic                      data_v_o;
   logic                      data_ready_i;

   // Handshake: upstream holds valid and payload stable until its yumi, which
   // fires only in the cycle the downstream valid/ready handshake completes.
   modport slave (
      input  hdr_i, hdr_v_i, data_i, data_v_i, hdr_ready_i, data_ready_i,
      output hdr_yumi_o, data_yumi_o, hdr_o, hdr_v_o, data_o, data_v_o
   );

   modport master (
      output hdr_i, hdr_v_i, data_i, data_v_i, hdr_ready_i, data_ready_i,
      input  hdr_yumi_o, data_yumi_o, hdr_o, hdr_v_o, data_o, data_v_o
   );
endinterface

// File: rtl/bp_mem_cmd_arbiter.sv
// Round-robin, message-granular arbiter between the core mem_cmd port (req 0)
// and the I/O-to-memory path (req 1); grant is held from header to last beat.
module bp_mem_cmd_arbiter #(
   parameter int hdr_width_p    = 88,
   parameter int data_width_p   = 64,
   parameter int size_lsb_p     = 0,
   parameter int has_data_bit_p = 3,
   parameter int max_beats_p    = 16
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   bp_mem_cmd_arbiter_if.slave bus,
   output logic [1:0]        state_o
);

   localparam int dbytes_lp     = data_width_p / 8;
   localparam int lg_dbytes_lp  = $clog2(dbytes_lp);
   localparam int cnt_width_lp  = $clog2(max_beats_p);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_e;

   state_e                  state_r, state_n;
   logic                    grant_r, grant_n;
   logic                    last_r, last_n;
   logic [cnt_width_lp-1:0] cnt_r, cnt_n;

   logic [hdr_width_p-1:0]  hdr_sel;
   logic [data_width_p-1:0] data_sel;
   logic                    data_v_sel;
   logic [2:0]              size;
   logic [31:0]             bytes;
   logic [31:0]             beats;
   logic [cnt_width_lp-1:0] cnt_load;

   logic [1:0]              hdr_yumi;
   logic [1:0]              data_yumi;
   logic                    hdr_v;
   logic                    data_v;

   assign hdr_sel    = grant_r ? bus.hdr_i[2*hdr_width_p-1:hdr_width_p]
                               : bus.hdr_i[hdr_width_p-1:0];
   assign data_sel   = grant_r ? bus.data_i[2*data_width_p-1:data_width_p]
                               : bus.data_i[data_width_p-1:0];
   assign data_v_sel = grant_r ? bus.data_v_i[1] : bus.data_v_i[0];
   assign size       = hdr_sel[size_lsb_p +: 3];

   // Beat count: one beat for anything that fits a single word, otherwise
   // bytes/dbytes clamped to the counter's range.
   always_comb begin
      bytes = 32'd1 << size;
      if (bytes <= 32'(dbytes_lp)) begin
         beats = 32'd1;
      end else begin
         beats = bytes >> lg_dbytes_lp;
      end
      if (beats > 32'(max_beats_p)) begin
         beats = 32'(max_beats_p);
      end
      cnt_load = cnt_width_lp'(beats - 32'd1);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= IDLE;
         grant_r <= 1'b0;
         last_r  <= 1'b1;
         cnt_r   <= '0;
      end else begin
         state_r <= state_n;
         grant_r <= grant_n;
         last_r  <= last_n;
         cnt_r   <= cnt_n;
      end
   end

   always_comb begin
      state_n   = state_r;
      grant_n   = grant_r;
      last_n    = last_r;
      cnt_n     = cnt_r;
      hdr_v     = 1'b0;
      data_v    = 1'b0;
      hdr_yumi  = 2'b00;
      data_yumi = 2'b00;

      unique case (state_r)
         IDLE: begin
            if (|bus.hdr_v_i) begin
               grant_n = (bus.hdr_v_i == 2'b11) ? ~last_r : bus.hdr_v_i[1];
               state_n = HDR;
            end
         end

         HDR: begin
            hdr_v = 1'b1;
            if (bus.hdr_ready_i) begin
               hdr_yumi[grant_r] = 1'b1;
               if (hdr_sel[has_data_bit_p]) begin
                  cnt_n   = cnt_load;
                  state_n = DATA;
               end else begin
                  last_n  = grant_r;
                  state_n = IDLE;
               end
            end
         end

         DATA: begin
            data_v = data_v_sel;
            if (data_v_sel && bus.data_ready_i) begin
               data_yumi[grant_r] = 1'b1;
               if (cnt_r == '0) begin
                  last_n  = grant_r;
                  state_n = IDLE;
               end else begin
                  cnt_n = cnt_r - 1'b1;
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.hdr_o       = hdr_sel;
   assign bus.hdr_v_o     = hdr_v;
   assign bus.data_o      = data_sel;
   assign bus.data_v_o    = data_v;
   assign bus.hdr_yumi_o  = hdr_yumi;
   assign bus.data_yumi_o = data_yumi;
   assign state_o         = state_r;

endmodule

// File: tb/tb_bp_mem_cmd_arbiter.sv
// Directed bench for bp_mem_cmd_arbiter: header-only, multi-beat writes,
// round-robin alternation, ready stalls and mid-message async reset.
module tb_bp_mem_cmd_arbiter;
   localparam int hw = 88;
   localparam int dw = 64;

   logic       clk;
   logic       reset_n;
   logic [1:0] state;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [dw-1:0] exp_q[$];

   bp_mem_cmd_arbiter_if #(.hdr_width_p(hw), .data_width_p(dw)) ifc ();

   bp_mem_cmd_arbiter #(
      .hdr_width_p(hw), .data_width_p(dw), .size_lsb_p(0),
      .has_data_bit_p(3), .max_beats_p(16)
   ) dut (
      .clk_i(clk),
      .reset_n_i(reset_n),
      .bus(ifc.slave),
      .state_o(state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [hw-1:0] mk_hdr(input logic has_data, input logic [2:0] size,
                                            input logic [7:0] tag);
      logic [hw-1:0] h;
      h         = '0;
      h[2:0]    = size;
      h[3]      = has_data;
      h[hw-1 -: 8] = tag;
      h[47:16]  = {tag, tag, tag, tag};
      return h;
   endfunction

   task automatic clear_inputs();
      ifc.hdr_i        = '0;
      ifc.hdr_v_i      = 2'b00;
      ifc.data_i       = '0;
      ifc.data_v_i     = 2'b00;
      ifc.hdr_ready_i  = 1'b1;
      ifc.data_ready_i = 1'b1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_state"}, 128'(state), 128'(0));
      check({tag, "_hdr_v"}, 128'(ifc.hdr_v_o), 128'(0));
      check({tag, "_data_v"}, 128'(ifc.data_v_o), 128'(0));
      check({tag, "_hdr_yumi"}, 128'(ifc.hdr_yumi_o), 128'(0));
      check({tag, "_data_yumi"}, 128'(ifc.data_yumi_o), 128'(0));
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One complete message from requester r; entered just after an edge with
   // the DUT in IDLE. nbeats = 0 means a header-only message.
   task automatic run_msg(input int r, input logic [hw-1:0] hdr, input int nbeats,
                          input logic [dw-1:0] base, input bit toggle_rdy);
      bit rdy;
      int guard;
      ifc.hdr_i[r*hw +: hw] = hdr;
      ifc.hdr_v_i[r]        = 1'b1;
      ifc.hdr_ready_i       = 1'b1;
      ifc.data_ready_i      = 1'b1;
      for (int i = 1; i <= nbeats; i++) exp_q.push_back(base + dw'(i));
      if (nbeats > 0) begin
         ifc.data_i[r*dw +: dw] = exp_q[0];
         ifc.data_v_i[r]        = 1'b1;
      end
      #1;
      check("idle_hdr_v", 128'(ifc.hdr_v_o), 128'(0));
      check("idle_data_yumi", 128'(ifc.data_yumi_o), 128'(0));
      @(posedge clk); #1;
      check("hdr_v", 128'(ifc.hdr_v_o), 128'(1));
      check("hdr_o", 128'(ifc.hdr_o), 128'(hdr));
      check("hdr_yumi", 128'(ifc.hdr_yumi_o), 128'(2'b01 << r));
      check("hdr_data_v", 128'(ifc.data_v_o), 128'(0));
      check("hdr_data_yumi", 128'(ifc.data_yumi_o), 128'(0));
      @(posedge clk); #1;
      ifc.hdr_v_i[r] = 1'b0;
      rdy   = 1'b1;
      guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
         ifc.data_ready_i = rdy;
         #1;
         check("beat_v", 128'(ifc.data_v_o), 128'(1));
         check("beat_data", 128'(ifc.data_o), 128'(exp_q[0]));
         check("beat_hdr_v", 128'(ifc.hdr_v_o), 128'(0));
         check("beat_yumi", 128'(ifc.data_yumi_o), rdy ? 128'(2'b01 << r) : 128'(0));
         @(posedge clk); #1;
         if (rdy) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) ifc.data_v_i[r] = 1'b0;
            else ifc.data_i[r*dw +: dw] = exp_q[0];
         end
         if (toggle_rdy) rdy = ~rdy;
         guard++;
      end
      check("beat_guard", 128'(guard < 100), 128'(1));
      exp_q.delete();
      ifc.data_ready_i = 1'b1;
      #1;
      check("end_state", 128'(state), 128'(0));
      check("end_data_v", 128'(ifc.data_v_o), 128'(0));
   endtask

   initial begin
      logic [hw-1:0] ha;
      logic [hw-1:0] hb;
      int            exp_g;

      do_reset();

      // Header-only from req0
      run_msg(0, mk_hdr(1'b0, 3'd3, 8'h11), 0, '0, 1'b0);

      // Req1 write of 64 bytes: 8 beats 0x1..0x8
      run_msg(1, mk_hdr(1'b1, 3'd6, 8'h22), 8, 64'h0, 1'b0);

      // 4-byte write: single beat
      run_msg(0, mk_hdr(1'b1, 3'd2, 8'h33), 1, 64'hCAFE_0000, 1'b0);

      // Round-robin with both requesters continuously valid
      do_reset();
      ha = mk_hdr(1'b0, 3'd3, 8'hA0);
      hb = mk_hdr(1'b0, 3'd3, 8'hB1);
      ifc.hdr_i   = {hb, ha};
      ifc.hdr_v_i = 2'b11;
      exp_g = 0;
      for (int n = 0; n < 6; n++) begin
         #1;
         check("rr_idle_hdr_v", 128'(ifc.hdr_v_o), 128'(0));
         @(posedge clk); #1;
         check("rr_yumi", 128'(ifc.hdr_yumi_o), 128'(2'b01 << exp_g));
         check("rr_hdr_o", 128'(ifc.hdr_o), exp_g ? 128'(hb) : 128'(ha));
         @(posedge clk); #1;
         exp_g ^= 1;
      end
      clear_inputs();

      // Req0 4-beat write with stalls while req1 waits; req1 granted afterwards
      do_reset();
      hb = mk_hdr(1'b0, 3'd0, 8'hB2);
      ifc.hdr_i[hw +: hw] = hb;
      ifc.hdr_v_i[1]      = 1'b1;
      run_msg(0, mk_hdr(1'b1, 3'd5, 8'h44), 4, 64'h100, 1'b1);
      @(posedge clk); #1;
      check("after_stall_yumi", 128'(ifc.hdr_yumi_o), 128'(2'b10));
      check("after_stall_hdr_o", 128'(ifc.hdr_o), 128'(hb));
      @(posedge clk); #1;
      clear_inputs();

      // Async reset after beat 2 of 8; next grant goes to req0
      do_reset();
      ifc.hdr_i[0 +: hw] = mk_hdr(1'b1, 3'd6, 8'h55);
      ifc.hdr_v_i[0]     = 1'b1;
      ifc.data_i[0 +: dw] = 64'h1;
      ifc.data_v_i[0]    = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      ifc.hdr_v_i[0] = 1'b0;
      @(posedge clk); #1;
      ifc.data_i[0 +: dw] = 64'h2;
      @(posedge clk); #1;
      ifc.data_i[0 +: dw] = 64'h3;
      check("mid_data_v", 128'(ifc.data_v_o), 128'(1));
      #2;
      reset_n = 1'b0;
      #1;
      check_quiet("async_rst");
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      ifc.hdr_i   = {mk_hdr(1'b0, 3'd3, 8'hB3), mk_hdr(1'b0, 3'd3, 8'hA3)};
      ifc.hdr_v_i = 2'b11;
      @(posedge clk); #1;
      check("post_rst_yumi", 128'(ifc.hdr_yumi_o), 128'(2'b01));
      clear_inputs();
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/bp_mem_cmd_arbiter.md
Name: bp_mem_cmd_arbiter

Overview:
- Two-requester, message-granular arbiter sharing a single memory command channel; the channel is split into a header stream and a data stream.
- Requester 0 is the unicore mem_cmd port. Requester 1 is the I/O-to-memory path.
- Output drives the chip's off-core memory command link.
- Grant is round-robin and stays locked to one requester from header acceptance until its last data beat.

Parameters:
- hdr_width_p, 88, header width in bits.
- data_width_p, 64, data beat width in bits; must be a power of two, at least 8.
- size_lsb_p, 0, bit index of the 3-bit size field in the header. Bytes = 1 << size.
- has_data_bit_p, 3, header bit index; 1 means the message carries data beats (write), 0 means header only.
- max_beats_p, 16, maximum beats per message; sets the counter width, clog2(max_beats_p).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- hdr_i  in  2*hdr_width_p  requester headers; requester r occupies slice r.
- hdr_v_i  in  2  header valid, one bit per requester.
- hdr_yumi_o  out  2  header consumed, one bit per requester.
- data_i  in  2*data_width_p  requester data beats.
- data_v_i  in  2  data valid, one bit per requester.
- data_yumi_o  out  2  data beat consumed, one bit per requester.
- hdr_o  out  hdr_width_p  arbitrated header.
- hdr_v_o  out  1  header valid.
- hdr_ready_i  in  1  downstream header ready.
- data_o  out  data_width_p  arbitrated data beat.
- data_v_o  out  1  data valid.
- data_ready_i  in  1  downstream data ready.

Behaviour:
- Reset is asynchronous, active-low.
  - state=IDLE, grant_r=0, last_r=1 (requester 0 wins first), cnt_r=0.
  - hdr_v_o=0, data_v_o=0, hdr_yumi_o=0, data_yumi_o=0.
  - hdr_o and data_o are don't-care while their valid is 0; drive the selected slice.
- Requesters must hold hdr_v_i/hdr_i stable until yumi, and likewise data_v_i/data_i. Yumi is asserted only in the cycle of the downstream handshake.
- State IDLE:
  - All outputs are 0.
  - Only one requester valid: grant_r ← that requester.
  - Both valid: grant_r ← ~last_r.
  - Any request moves to HDR. Header presentation therefore takes 1 cycle of arbitration latency.
- State HDR:
  - hdr_o = hdr_i[grant_r], hdr_v_o = 1.
  - On hdr_ready_i: hdr_yumi_o[grant_r] = 1 that cycle.
    - has_data bit = 1: cnt_r ← beats-1, go to DATA.
    - has_data bit = 0: last_r ← grant_r, go to IDLE.
  - Without hdr_ready_i: hold; no timeout.
- Beat computation, where dbytes = data_width_p/8:
  - beats = 1 if (1 << size) ≤ dbytes.
  - Otherwise beats = (1 << size)/dbytes, saturated at max_beats_p.
- State DATA:
  - data_o = data_i[grant_r], data_v_o = data_v_i[grant_r].
  - On data_v_o & data_ready_i: data_yumi_o[grant_r] = 1.
    - cnt_r = 0: last_r ← grant_r, go to IDLE.
    - Otherwise cnt_r ← cnt_r-1.
  - data_yumi_o of the non-granted requester is always 0.
  - The non-granted requester's hdr_v_i is ignored until IDLE; no preemption.
- Data beats arriving before their header are not consumed; they wait for DATA.
- Throughput:
  - One header per 2 cycles minimum (IDLE+HDR).
  - Data runs at 1 beat/cycle when valid and ready are both high.
- Never: hdr_v_o and data_v_o asserted in the same cycle; yumi to both requesters in the same cycle.
- Reset asserted mid-message returns immediately to the reset state. The partial message is abandoned, and upstream is expected to be reset too.

Test Plan:
- Req0 header only (has_data=0, size=3), ready held high → hdr_v_o at cycle+1; hdr_yumi_o=2'b01 that cycle; IDLE at cycle+2; data_v_o never 1.
- Req1 write, size=6 (64 B), data_width_p=64 → header, then exactly 8 beats 0x1..0x8 in order on data_o; data_yumi_o[1] pulses 8 times; IDLE after the 8th beat.
- Both hdr_v_i high right after reset, both header-only → req0 granted first, then req1, then req0 (alternating); no grant is repeated while the other is pending.
- Req0 write of 4 beats with data_ready_i toggling 1,0,1,0… and req1 valid throughout → req1 is not granted until the 4th req0 beat is accepted; data_o is stable during stall cycles.
- size=2 (4 B) write with has_data=1 → exactly 1 data beat.
- reset_n_i dropped asynchronously after beat 2 of 8 → all outputs 0 immediately; after release, the next grant goes to req0.
